// File: rtl/hazard_ctl.sv
// Pipeline hazard controller for the 5-stage MIPS core: per-stage stall/flush
// generation, mult/div occupancy tracking and a data-memory wait watchdog.
module hazard_ctl #(
  parameter int MD_LAT      = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       id_md_use,
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic       ex_branch_taken,
  input  logic       ex_md_start,
  input  logic       mem_req,
  input  logic       mem_ack,
  output logic       stall_pc,
  output logic       stall_ifid,
  output logic       stall_idex,
  output logic       stall_exmem,
  output logic       flush_ifid,
  output logic       flush_idex,
  output logic       flush_memwb,
  output logic       md_busy,
  output logic       mem_err
);

  localparam logic [7:0] MD_LAT_C  = 8'(MD_LAT);
  localparam logic [7:0] TIMEOUT_M1 = 8'(MEM_TIMEOUT - 1);

  logic [7:0] md_cnt;
  logic [7:0] wait_cnt;
  logic       frz;
  logic       branch;
  logic       load_use;
  logic       md_lock;
  logic       interlock;

  assign frz     = mem_req & ~mem_ack;
  assign md_busy = (md_cnt != 8'd0);
  assign branch  = ~frz & ex_branch_taken;

  assign load_use = id_valid & ex_memread & (ex_rt != 5'd0) &
                    ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  assign md_lock  = id_valid & id_md_use & md_busy;
  // A squashed ID instruction cannot create an interlock, so branch wins.
  assign interlock = ~frz & ~ex_branch_taken & (load_use | md_lock);

  assign stall_pc    = frz | interlock;
  assign stall_ifid  = frz | interlock;
  assign stall_idex  = frz;
  assign stall_exmem = frz;
  assign flush_ifid  = branch;
  assign flush_idex  = branch | interlock;
  assign flush_memwb = frz;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt   <= 8'd0;
      wait_cnt <= 8'd0;
      mem_err  <= 1'b0;
    end else begin
      // The mult/div unit keeps counting through a freeze.
      if (ex_md_start && !frz && md_cnt == 8'd0)
        md_cnt <= MD_LAT_C;
      else if (md_cnt != 8'd0)
        md_cnt <= md_cnt - 8'd1;

      if (frz) begin
        if (wait_cnt != 8'hFF)
          wait_cnt <= wait_cnt + 8'd1;
        if (wait_cnt == TIMEOUT_M1)
          mem_err <= 1'b1;
      end else begin
        wait_cnt <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctl.sv
// Directed testbench for hazard_ctl (MD_LAT = 4, MEM_TIMEOUT = 8).
module tb_hazard_ctl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_uses_rt, id_md_use;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       ex_memread, ex_branch_taken, ex_md_start;
  logic       mem_req, mem_ack;
  logic       stall_pc, stall_ifid, stall_idex, stall_exmem;
  logic       flush_ifid, flush_idex, flush_memwb, md_busy, mem_err;
  logic [8:0] outv;

  int checks = 0;
  int errors = 0;

  hazard_ctl #(.MD_LAT(4), .MEM_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_md_use(id_md_use),
    .ex_memread(ex_memread), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken), .ex_md_start(ex_md_start),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid),
    .stall_idex(stall_idex), .stall_exmem(stall_exmem),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .flush_memwb(flush_memwb), .md_busy(md_busy), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // {stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex, flush_memwb, md_busy, mem_err}
  assign outv = {stall_pc, stall_ifid, stall_idex, stall_exmem,
                 flush_ifid, flush_idex, flush_memwb, md_busy, mem_err};

  localparam logic [8:0] NONE   = 9'b000000000;
  localparam logic [8:0] LU     = 9'b110001000;
  localparam logic [8:0] BR     = 9'b000011000;
  localparam logic [8:0] FRZ    = 9'b111100100;
  localparam logic [8:0] BUSY   = 9'b000000010;
  localparam logic [8:0] MDLOCK = 9'b110001010;
  localparam logic [8:0] ERR    = 9'b000000001;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [8:0] exp);
    #1;
    checks++;
    assert (outv === exp)
    else begin
      errors++;
      $error("FAIL %s got %b exp %b", tag, outv, exp);
    end
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; id_md_use = 0;
    ex_memread = 0; ex_rt = 0; ex_branch_taken = 0; ex_md_start = 0;
    mem_req = 0; mem_ack = 0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    tick();
    chk("reset_hold", NONE);
    tick();
    reset = 1'b0;
    chk("reset_release", NONE);

    // Load-use variants
    ex_memread = 1; ex_rt = 5; id_rs = 5; id_valid = 1;
    chk("lu_rs", LU);
    ex_rt = 0;
    chk("lu_rt_zero", NONE);
    ex_rt = 5; id_rs = 0; id_rt = 5; id_uses_rt = 0;
    chk("lu_rt_unused", NONE);
    id_uses_rt = 1;
    chk("lu_rt_used", LU);
    id_valid = 0;
    chk("lu_not_valid", NONE);
    id_valid = 1;

    // Branch beats load-use
    ex_branch_taken = 1;
    chk("branch_over_lu", BR);

    // Freeze defers the branch
    mem_req = 1; mem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("freeze_%0d", i), FRZ);
      tick();
    end
    mem_ack = 1;
    chk("freeze_release_branch", BR);
    tick();
    clear_inputs();
    chk("idle_after_freeze", NONE);
    tick();

    // Mult/div occupancy: start sampled at edge T
    ex_md_start = 1;
    chk("md_start", NONE);
    tick();
    ex_md_start = 0; id_md_use = 1; id_valid = 1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("md_lock_T+%0d", i), MDLOCK);
      tick();
    end
    chk("md_done_T+5", NONE);
    clear_inputs();
    tick();

    // Watchdog: mem_err visible 8 cycles after freeze begins
    mem_req = 1;
    for (int i = 0; i <= 8; i++) begin
      chk($sformatf("wdog_cycle_%0d", i), (i == 8) ? (FRZ | ERR) : FRZ);
      tick();
    end
    mem_ack = 1;
    chk("wdog_ack", ERR);
    tick();
    clear_inputs();
    chk("wdog_sticky_0", ERR);
    tick();
    tick();
    chk("wdog_sticky_1", ERR);
    #2 reset = 1'b1;
    chk("wdog_reset_clears", NONE);
    tick();
    reset = 1'b0;
    tick();

    // Reset mid-count aborts the countdown asynchronously
    ex_md_start = 1;
    tick();
    ex_md_start = 0;
    tick();
    tick();
    chk("md_cnt_two", BUSY);
    #2 reset = 1'b1;
    chk("md_async_reset", NONE);
    tick();
    reset = 1'b0;
    ex_md_start = 1;
    chk("md_restart_pre", NONE);
    tick();
    ex_md_start = 0;
    chk("md_restart_accepted", BUSY);
    tick(); tick(); tick();
    chk("md_restart_last", BUSY);
    tick();
    chk("md_restart_done", NONE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
